// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED arbiter: colour struct, arbiter state enum, PWM width.
package rgb_led_pkg;

  localparam int PWM_BITS = 8;

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_color_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rgb_led_arbiter_pwm.sv
// 8-bit free-running PWM with registered active-low pin drivers (0 = lit).
module rgb_pwm
  import rgb_led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  rgb_color_t duty,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]          pin_q, pin_d;

  // Strict compare: duty 0 never lights, duty 255 lights all but one step.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pin_d     = {~(pwm_cnt_q < duty.r), ~(pwm_cnt_q < duty.g), ~(pwm_cnt_q < duty.b)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pin_q     <= 3'b111;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pin_q     <= pin_d;
    end
  end

  assign {rgb_r, rgb_g, rgb_b} = pin_q;

endmodule

// File: rtl/rgb_led_arbiter.sv
// Time-slot arbiter sharing one active-low RGB LED between NUM_REQ sources.
// Define RGB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SLOT_CYCLES = 2_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][23:0] req_color,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     slot_done,
  output logic                     RGB_R,
  output logic                     RGB_G,
  output logic                     RGB_B
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  rgb_color_t         cur_color_q, cur_color_d;
  logic               slot_done_q, slot_done_d;
  logic               win_any, grant_go, slot_end;
  logic [PTR_W-1:0]   win_idx;
  rgb_color_t         duty;

`ifdef RGB_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last write.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_any = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Search order starts at ptr; the previous owner sits last, so it only wins when alone.
  always_comb begin
    int s;
    s       = 0;
    win_any = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (req[s]) begin
        win_any = 1'b1;
        win_idx = PTR_W'(s);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_go) ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign slot_end = (state_q == ARB_GRANT) && (~|(req & gnt_q) || slot_cnt_q == SLOT_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    slot_cnt_d  = slot_cnt_q;
    cur_color_d = cur_color_q;
    slot_done_d = 1'b0;
    grant_go    = 1'b0;
    case (state_q)
      ARB_IDLE: grant_go = win_any;
      ARB_GRANT: begin
        if (slot_end) begin
          slot_done_d = 1'b1;
          grant_go    = win_any;
          if (!win_any) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant_go) begin
      state_d     = ARB_GRANT;
      gnt_d       = NUM_REQ'(1) << win_idx;
      cur_color_d = rgb_color_t'(req_color[win_idx]);
      slot_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      slot_cnt_q  <= '0;
      cur_color_q <= '0;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      slot_cnt_q  <= slot_cnt_d;
      cur_color_q <= cur_color_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign duty      = (state_q == ARB_GRANT) ? cur_color_q : '0;
  assign gnt       = gnt_q;
  assign slot_done = slot_done_q;

  rgb_pwm u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .duty  (duty),
    .rgb_r (RGB_R),
    .rgb_g (RGB_G),
    .rgb_b (RGB_B)
  );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/slot_done events, a monitor pops on each event.
module tb_rgb_led_arbiter;

  localparam int NR = 4;
  localparam int SC = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR-1:0]       req = '0;
  logic [NR-1:0][23:0] req_color = '0;
  logic [NR-1:0]       gnt;
  logic                slot_done;
  logic                RGB_R, RGB_G, RGB_B;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          sd;
    int            gap;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            last_cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [NR-1:0] prev_gnt = '0;

  rgb_led_arbiter #(.NUM_REQ(NR), .SLOT_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_color (req_color),
    .gnt       (gnt),
    .slot_done (slot_done),
    .RGB_R     (RGB_R),
    .RGB_G     (RGB_G),
    .RGB_B     (RGB_B)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // An event is any gnt change or a slot_done pulse; gap is edges since the previous event/mark.
  always @(negedge clk) begin
    exp_t e;
    int   gap;
    if (rst_n && (gnt != prev_gnt || slot_done)) begin
      vectors++;
      gap = cyc - last_cyc;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got gnt=%b slot_done=%b gap=%0d, queue empty", gnt, slot_done, gap);
      end else begin
        e = sb.pop_front();
        if (gnt !== e.gnt || slot_done !== e.sd || gap != e.gap) begin
          miscompares++;
          $display("FAIL event: got gnt=%b slot_done=%b gap=%0d, expected gnt=%b slot_done=%b gap=%0d",
                   gnt, slot_done, gap, e.gnt, e.sd, e.gap);
        end
      end
      last_cyc = cyc;
    end
    prev_gnt = gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    last_cyc = cyc;
  endtask

  task automatic expect_ev(input logic [NR-1:0] g, input logic sd, input int gap);
    exp_t e;
    e.gnt = g;
    e.sd  = sd;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int r_lit, g_lit, b_lit;
    r_lit = 0; g_lit = 0; b_lit = 0;

    // Reset held 3 edges while every source requests.
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_gnt", int'(gnt), 0);
      check("rst_slot_done", int'(slot_done), 0);
      check("rst_pins", int'({RGB_R, RGB_G, RGB_B}), 7);
    end
    rst_n = 1'b1;
    mark();

`ifdef RGB_ARB_FIXED_PRIO_EN
    expect_ev(4'b0001, 1'b0, 1);
    expect_ev(4'b0001, 1'b1, 8);
    expect_ev(4'b0001, 1'b1, 8);
    expect_ev(4'b0010, 1'b1, 1);
    expect_ev(4'b0010, 1'b1, 8);
    expect_ev(4'b0010, 1'b1, 8);
    expect_ev(4'b0010, 1'b1, 8);
    expect_ev(4'b0100, 1'b1, 3);
    expect_ev(4'b0000, 1'b1, 2);
    tick(17);
    req = 4'b0110;
    tick(27);
    req = 4'b0100;
    tick(2);
    req = '0;
`else
    // Round-robin with all four requesting, then release.
    expect_ev(4'b0001, 1'b0, 1);
    expect_ev(4'b0010, 1'b1, 8);
    expect_ev(4'b0100, 1'b1, 8);
    expect_ev(4'b1000, 1'b1, 8);
    expect_ev(4'b0001, 1'b1, 8);
    expect_ev(4'b0000, 1'b1, 1);
    tick(33);
    req = '0;

    // Early drop: req0 alone, released 3 cycles after its grant.
    tick(2);
    req = 4'b0001;
    mark();
    expect_ev(4'b0001, 1'b0, 1);
    expect_ev(4'b0000, 1'b1, 4);
    tick(4);
    req = '0;

    // Owner drops on the last slot cycle while req2 waits: one slot end, direct handover.
    tick(2);
    req = 4'b0110;
    mark();
    expect_ev(4'b0010, 1'b0, 1);
    expect_ev(4'b0100, 1'b1, 8);
    expect_ev(4'b0000, 1'b1, 3);
    tick(8);
    req = 4'b0100;
    tick(3);
    req = '0;
    tick(2);
    check("idle_gnt", int'(gnt), 0);
    check("idle_pins", int'({RGB_R, RGB_G, RGB_B}), 7);

    // PWM: sole requester 3 re-granted every slot; a mid-slot colour change must not show.
    req_color[3] = 24'h4000FF;
    req = 4'b1000;
    mark();
    expect_ev(4'b1000, 1'b0, 1);
    for (int i = 0; i < 32; i++) expect_ev(4'b1000, 1'b1, 8);
    expect_ev(4'b0000, 1'b1, 3);
    tick(1);
    for (int k = 1; k <= 257; k++) begin
      tick(1);
      if (k >= 2) begin
        r_lit += int'(!RGB_R);
        g_lit += int'(!RGB_G);
        b_lit += int'(!RGB_B);
      end
      if (k == 2) req_color[3] = 24'hFFFF00;
      if (k == 5) req_color[3] = 24'h4000FF;
    end
    tick(1);
    req = '0;
    check("pwm_r_lit", r_lit, 64);
    check("pwm_g_lit", g_lit, 0);
    check("pwm_b_lit", b_lit, 255);
`endif

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
    check("pending_events", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Time-slot arbiter that shares the single on-board active-low RGB LED between several status sources. Each requester asks for the LED with a 24-bit colour. The arbiter grants one requester at a time for a bounded dwell slot. It drives the LED pins through an 8-bit PWM stage, so each source gets real brightness rather than on/off. It sits between the application's status/pattern generators and the top-level `RGB_R/G/B` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be 2–8.
- `SLOT_CYCLES`, default 2_000_000: maximum dwell per grant in clk cycles (≈0.166 s at 12 MHz); must be ≥ 2.
- `clk`, input, 1: system clock, 12 MHz.
- `rst_n`, input, 1: one clock; reset is synchronous and active-low.
- `req`, input, NUM_REQ: level request, bit i belongs to requester i.
- `req_color`, input, NUM_REQ×24: per requester `{R[7:0],G[7:0],B[7:0]}` intensity.
- `gnt`, output, NUM_REQ: one-hot current owner; all-zero when idle.
- `slot_done`, output, 1: one-cycle pulse when a slot ends.
- `RGB_R`, `RGB_G`, `RGB_B`, output, 1 each: LED pins, active-low (0 = lit).

## Operation
- Two states:
  - IDLE: no owner, LED dark.
  - GRANT: owner latched, LED shows owner's colour.
- IDLE → GRANT on any clock edge with `req != 0`. The winner is chosen by round-robin search starting at pointer `ptr`.
- On a grant to i:
  - `gnt` becomes one-hot i.
  - `req_color[i]` is latched into `cur_color`. The colour is sampled only at grant; changes mid-slot are ignored.
  - `ptr` ← (i+1) mod NUM_REQ.
- `slot_cnt` clears on every grant and increments each GRANT cycle.
- A slot ends when either `req[owner]` is low or `slot_cnt == SLOT_CYCLES-1`. Both in the same cycle count as one end.
- At slot end, on the same edge:
  - If any `req` bit is high, re-arbitrate from the updated `ptr` and go GRANT to the new winner, with no idle gap. The old owner may win again only if it is the sole requester.
  - Otherwise go to IDLE with `gnt` = 0.
- `slot_done` is registered: high for exactly the cycle after the slot-end edge.
- PWM:
  - Free-running 8-bit `pwm_cnt`, period 256 cycles, never reset by grants.
  - A channel is lit when `pwm_cnt < duty`. Duty 0 is always dark; duty 255 is lit 255/256 cycles.
  - Duty is `cur_color` in GRANT and 0 in IDLE.
- `slot_cnt` width is `$clog2(SLOT_CYCLES)`. It never exceeds SLOT_CYCLES-1.

## Timing
- Reset values, applied on the first edge with `rst_n` low:
  - `gnt`=0, `slot_done`=0, `RGB_R/G/B`=1 (dark), `ptr`=0, `pwm_cnt`=0, `slot_cnt`=0, `cur_color`=0, state IDLE.
- Reset mid-slot drops the owner immediately with no `slot_done` pulse.
- Request → grant latency: `gnt` is visible 1 cycle after the edge that samples `req`.
- Grant → LED latency: the pin outputs are registered, so the new colour appears at the first PWM compare 1 cycle after `gnt` changes.
- Maximum hold: `gnt` is high for exactly SLOT_CYCLES cycles when `req` stays asserted.
- Early drop: when the owner drops `req` in cycle k, `gnt` changes on edge k+1.

## Configuration
- `RGB_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, lowest index wins.
  - `ptr` is removed.
  - Slot expiry still forces re-arbitration, so a higher-priority requester regains the LED at once when it is still requesting.
- `RGB_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Structure
- Package `rgb_led_pkg` holds:
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_color_t`
  - state enum `arb_state_t` {ARB_IDLE, ARB_GRANT}
  - constant `PWM_BITS = 8`
- Sub-module `rgb_pwm` contains the PWM counter, the compare, and the active-low registered pin drivers. Input is `rgb_color_t`.
- The top module contains the arbiter FSM, `ptr`, and `slot_cnt`.

## Test plan
All scenarios use NUM_REQ=4 and SLOT_CYCLES=8.
- Reset: hold `rst_n`=0 for 3 cycles with `req`=4'b1111 → `gnt`=0, pins=1, `slot_done`=0 throughout; first grant is `gnt`=4'b0001 one cycle after release.
- Round-robin: `req`=4'b1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each exactly 8 cycles, with a `slot_done` pulse between slots.
- Early drop: req0 only, deasserted 3 cycles after grant → `gnt`=0 the next cycle, one `slot_done` pulse, then IDLE.
- Simultaneous end: owner drops `req` on the cycle `slot_cnt`=7 while req2 is high → exactly one `slot_done`, and `gnt` moves directly to 4'b0100.
- PWM: grant with colour {8'd64, 8'd0, 8'd255} → over 256 cycles, `RGB_R` low 64 cycles, `RGB_G` never low, `RGB_B` low 255 cycles; colour change mid-slot has no effect.
- Fixed priority, with `RGB_ARB_FIXED_PRIO_EN` defined: `req`=4'b0110 held → `gnt` stays 4'b0010 across slot expiries; req2 is granted only after req1 drops.
